// File: rtl/pipe_fp_pkg.sv
// Shared types for the FP hazard scoreboard: in-flight entry record and its match helper.
package pipe_fp_pkg;

    localparam int unsigned RN_W_DEFAULT = 5;

    typedef struct packed {
        logic                    v;
        logic [RN_W_DEFAULT-1:0] rn;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '{v: 1'b0, rn: '0};

    function automatic logic sb_match(sb_entry_t entry, logic [RN_W_DEFAULT-1:0] rn);
        return entry.v && (entry.rn == rn);
    endfunction

endpackage

// File: rtl/pipe_fp_scoreboard_if.sv
// ID-stage <-> FP scoreboard bundle: decoded FP instruction in, stall/forward/long-op status out.
interface pipe_fp_scoreboard_if import pipe_fp_pkg::*; #(
    parameter int unsigned RN_W = RN_W_DEFAULT
);

    logic            id_valid;
    logic            id_cancel;
    logic [RN_W-1:0] id_fs;
    logic [RN_W-1:0] id_ft;
    logic            id_use_fs;
    logic            id_use_ft;
    logic [RN_W-1:0] id_fd;
    logic            id_wf;
    logic            id_long;
    logic            pipe_hold;
    logic            stall;
    logic            fwd_fs;
    logic            fwd_ft;
    logic            long_busy;
    logic            long_wr;
    logic [RN_W-1:0] long_rn;

    modport master (
        output id_valid, id_cancel, id_fs, id_ft, id_use_fs, id_use_ft, id_fd, id_wf, id_long,
        output pipe_hold,
        input  stall, fwd_fs, fwd_ft, long_busy, long_wr, long_rn
    );

    modport slave (
        input  id_valid, id_cancel, id_fs, id_ft, id_use_fs, id_use_ft, id_fd, id_wf, id_long,
        input  pipe_hold,
        output stall, fwd_fs, fwd_ft, long_busy, long_wr, long_rn
    );

endinterface

// File: rtl/pipe_fp_long_ctr.sv
// Div/sqrt occupancy counter: loads LONG_LAT on issue, counts down to the FPR write cycle.
module pipe_fp_long_ctr import pipe_fp_pkg::*; #(
    parameter int unsigned RN_W     = RN_W_DEFAULT,
    parameter int unsigned LONG_LAT = 16,
    parameter int unsigned CNT_W    = $clog2(LONG_LAT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             hold,
    input  logic [RN_W-1:0]  load_rn,
    output logic [CNT_W-1:0] cnt,
    output logic             long_busy,
    output logic             long_wr,
    output logic [RN_W-1:0]  long_rn
);

    logic [CNT_W-1:0] cnt_q;
    logic [RN_W-1:0]  long_rn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            long_rn_q <= '0;
        end else if (load) begin
            cnt_q     <= CNT_W'(LONG_LAT);
            long_rn_q <= load_rn;
        end else if ((cnt_q != '0) && !hold) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign cnt       = cnt_q;
    assign long_rn   = long_rn_q;
    assign long_busy = (cnt_q != '0);
    // The write happens on the edge that ends the cnt==1 cycle, unless frozen.
    assign long_wr   = (cnt_q == CNT_W'(1)) && !hold;

endmodule

// File: rtl/pipe_fp_scoreboard.sv
// FP hazard scoreboard for the ID stage: DEPTH-stage destination tracker plus one div/sqrt unit.
// Optional macro PIPE_SB_FWD_EN: forward last-stage result instead of stalling one more cycle.
module pipe_fp_scoreboard import pipe_fp_pkg::*; #(
    parameter int unsigned RN_W     = RN_W_DEFAULT,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LONG_LAT = 16,
    parameter int unsigned CNT_W    = $clog2(LONG_LAT + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    pipe_fp_scoreboard_if.slave sb
);

    sb_entry_t        entry_q [DEPTH];
    logic [CNT_W-1:0] cnt;
    logic             issue;
    logic             id_live;
    logic             near_fs, near_ft;
    logic             last_fs, last_ft;
    logic             long_fs, long_ft;
    logic             haz_fs, haz_ft;
    logic             fwd_ok_fs, fwd_ok_ft;
    logic             struct_haz, waw_haz;

    assign id_live = sb.id_valid & ~sb.id_cancel;
    assign issue   = id_live & ~sb.stall & ~sb.pipe_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) entry_q[i] <= SB_BUBBLE;
        end else if (!sb.pipe_hold) begin
            entry_q[0] <= '{v: issue & sb.id_wf & ~sb.id_long, rn: sb.id_fd};
            for (int i = 1; i < int'(DEPTH); i++) entry_q[i] <= entry_q[i-1];
        end
    end

    pipe_fp_long_ctr #(
        .RN_W     (RN_W),
        .LONG_LAT (LONG_LAT),
        .CNT_W    (CNT_W)
    ) u_long_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (issue & sb.id_long),
        .hold      (sb.pipe_hold),
        .load_rn   (sb.id_fd),
        .cnt       (cnt),
        .long_busy (sb.long_busy),
        .long_wr   (sb.long_wr),
        .long_rn   (sb.long_rn)
    );

    // Any match before the last stage wins over a last-stage match (youngest decides).
    always_comb begin
        near_fs = 1'b0;
        near_ft = 1'b0;
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            near_fs |= sb_match(entry_q[i], sb.id_fs);
            near_ft |= sb_match(entry_q[i], sb.id_ft);
        end
    end

    assign last_fs = sb_match(entry_q[DEPTH-1], sb.id_fs);
    assign last_ft = sb_match(entry_q[DEPTH-1], sb.id_ft);

    // The long unit never forwards, so a pending write to a source always stalls.
    assign long_fs = sb.long_busy & (sb.long_rn == sb.id_fs);
    assign long_ft = sb.long_busy & (sb.long_rn == sb.id_ft);

    assign haz_fs    = sb.id_use_fs & (near_fs | long_fs);
    assign haz_ft    = sb.id_use_ft & (near_ft | long_ft);
    assign fwd_ok_fs = sb.id_use_fs & last_fs & ~near_fs & ~long_fs;
    assign fwd_ok_ft = sb.id_use_ft & last_ft & ~near_ft & ~long_ft;

    assign struct_haz = sb.id_long & sb.long_busy & (cnt != CNT_W'(1));
    // A short op to the same FPR would otherwise retire before the div/sqrt and be overwritten.
    assign waw_haz    = sb.id_wf & sb.long_busy & (sb.long_rn == sb.id_fd) &
                        (int'(cnt) > int'(DEPTH));

`ifdef PIPE_SB_FWD_EN
    assign sb.stall  = id_live & (haz_fs | haz_ft | struct_haz | waw_haz);
    assign sb.fwd_fs = id_live & fwd_ok_fs;
    assign sb.fwd_ft = id_live & fwd_ok_ft;
`else
    assign sb.stall  = id_live & (haz_fs | haz_ft | fwd_ok_fs | fwd_ok_ft | struct_haz | waw_haz);
    assign sb.fwd_fs = 1'b0;
    assign sb.fwd_ft = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_fp_scoreboard.sv
// Directed bench for pipe_fp_scoreboard (DEPTH=3, LONG_LAT=16); expectations follow PIPE_SB_FWD_EN.
module tb_pipe_fp_scoreboard;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   n;
    int   wr_at;
    int   wr_rn;
    int   wcnt;

    pipe_fp_scoreboard_if #(.RN_W(5)) sb ();

    pipe_fp_scoreboard #(
        .RN_W     (5),
        .DEPTH    (3),
        .LONG_LAT (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic c, input int fs, input logic ufs,
                         input int ft, input logic uft, input int fd, input logic wf,
                         input logic lng);
        sb.id_valid  = v;
        sb.id_cancel = c;
        sb.id_fs     = 5'(fs);
        sb.id_use_fs = ufs;
        sb.id_ft     = 5'(ft);
        sb.id_use_ft = uft;
        sb.id_fd     = 5'(fd);
        sb.id_wf     = wf;
        sb.id_long   = lng;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // Inputs change 1 ns after the active edge; outputs are sampled mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #4;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        sb.pipe_hold = 1'b0;
        drive(1'b1, 1'b0, 0, 1'b1, 0, 1'b1, 0, 1'b1, 1'b1);
        #2;
        chk("rst_stall", sb.stall, 0);
        chk("rst_fwd_fs", sb.fwd_fs, 0);
        chk("rst_fwd_ft", sb.fwd_ft, 0);
        chk("rst_busy", sb.long_busy, 0);
        chk("rst_long_wr", sb.long_wr, 0);
        bubble();
        step();
        rst_n = 1'b1;
        step();

        // 1: reset in the middle of a div (cnt=5)
        drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 8, 1'b1, 1'b1);
        look();
        chk("t1_div_issue_stall", sb.stall, 0);
        step();
        bubble();
        repeat (11) step();
        look();
        chk("t1_busy_cnt5", sb.long_busy, 1);
        drive(1'b1, 1'b0, 8, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
        #1;
        chk("t1_raw_before_rst", sb.stall, 1);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_stall", sb.stall, 0);
        chk("t1_rst_busy", sb.long_busy, 0);
        chk("t1_rst_long_wr", sb.long_wr, 0);
        step();
        rst_n = 1'b1;
        look();
        chk("t1_after_rst_stall", sb.stall, 0);
        bubble();
        wcnt = 0;
        repeat (20) begin
            step();
            look();
            wcnt += int'(sb.long_wr);
        end
        chk("t1_no_long_wr", wcnt, 0);

        // 2: add.s f4 then add.s f6,f4,f2
        drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 4, 1'b1, 1'b0);
        step();
        drive(1'b1, 1'b0, 4, 1'b1, 2, 1'b1, 6, 1'b1, 1'b0);
        look();
        chk("t2_stall_c1", sb.stall, 1);
        chk("t2_fwd_fs_c1", sb.fwd_fs, 0);
        step();
        look();
        chk("t2_stall_c2", sb.stall, 1);
        step();
        look();
`ifdef PIPE_SB_FWD_EN
        chk("t2_stall_c3", sb.stall, 0);
        chk("t2_fwd_fs_c3", sb.fwd_fs, 1);
        chk("t2_fwd_ft_c3", sb.fwd_ft, 0);
        step();
`else
        chk("t2_stall_c3", sb.stall, 1);
        chk("t2_fwd_fs_c3", sb.fwd_fs, 0);
        step();
        look();
        chk("t2_stall_c4", sb.stall, 0);
        step();
`endif
        bubble();
        repeat (4) step();

        // 3: div.s f8 then mul.s f10,f8,f1
        drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 8, 1'b1, 1'b1);
        step();
        drive(1'b1, 1'b0, 8, 1'b1, 1, 1'b1, 10, 1'b1, 1'b0);
        look();
        n = 0;
        wr_at = 0;
        wr_rn = 0;
        while (sb.stall && n < 40) begin
            n++;
            if (sb.long_wr) begin
                wr_at = n;
                wr_rn = int'(sb.long_rn);
            end
            step();
            look();
        end
        chk("t3_stall_cycles", n, 16);
        chk("t3_long_wr_cycle", wr_at, 16);
        chk("t3_long_rn", wr_rn, 8);
        chk("t3_busy_done", sb.long_busy, 0);
        step();
        bubble();
        repeat (4) step();

        // 4: div.s f8 then div.s f9 (structural)
        drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 8, 1'b1, 1'b1);
        step();
        drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b1);
        look();
        n = 0;
        while (sb.stall && n < 40) begin
            n++;
            step();
            look();
        end
        chk("t4_struct_stalls", n, 15);
        chk("t4_wr_at_issue", sb.long_wr, 1);
        chk("t4_rn_at_issue", sb.long_rn, 8);
        step();
        bubble();
        look();
        chk("t4_busy_reload", sb.long_busy, 1);
        chk("t4_rn_reload", sb.long_rn, 9);
        n = 1;
        while (!sb.long_wr && n < 40) begin
            step();
            look();
            n++;
        end
        chk("t4_reload_latency", n, 16);
        step();
        look();
        chk("t4_busy_drained", sb.long_busy, 0);

        // 7: div.s f16 then add.s f16 (WAW)
        drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 16, 1'b1, 1'b1);
        step();
        drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 16, 1'b1, 1'b0);
        look();
        n = 0;
        while (sb.stall && n < 40) begin
            n++;
            step();
            look();
        end
        chk("t7_waw_stalls", n, 13);
        step();
        bubble();
        repeat (5) step();
        look();
        chk("t7_busy_drained", sb.long_busy, 0);

        // 5: pipe_hold for 4 cycles with a div and an add in flight
        drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 12, 1'b1, 1'b1);
        step();
        drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 14, 1'b1, 1'b0);
        step();
        drive(1'b1, 1'b0, 14, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
        sb.pipe_hold = 1'b1;
        look();
        chk("t5_hold_stall_h1", sb.stall, 1);
        chk("t5_hold_wr_h1", sb.long_wr, 0);
        repeat (3) begin
            step();
            look();
            chk("t5_hold_stall", sb.stall, 1);
            chk("t5_hold_busy", sb.long_busy, 1);
            chk("t5_hold_wr", sb.long_wr, 0);
        end
        step();
        sb.pipe_hold = 1'b0;
        look();
        chk("t5_release_entry0", sb.stall, 1);
        bubble();
        n = 1;
        while (!sb.long_wr && n < 40) begin
            step();
            look();
            n++;
        end
        chk("t5_cnt_frozen", n, 15);
        sb.pipe_hold = 1'b1;
        #1;
        chk("t5_hold_masks_wr", sb.long_wr, 0);
        step();
        look();
        chk("t5_hold_cnt1_wr", sb.long_wr, 0);
        chk("t5_hold_cnt1_busy", sb.long_busy, 1);
        sb.pipe_hold = 1'b0;
        #1;
        chk("t5_release_wr", sb.long_wr, 1);
        step();
        look();
        chk("t5_busy_done", sb.long_busy, 0);
        bubble();
        repeat (4) step();

        // 6: cancelled instruction with a hazard present
        drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 20, 1'b1, 1'b0);
        step();
        drive(1'b1, 1'b1, 20, 1'b1, 0, 1'b0, 22, 1'b1, 1'b0);
        look();
        chk("t6_cancel_stall", sb.stall, 0);
        chk("t6_cancel_fwd", sb.fwd_fs, 0);
        step();
        drive(1'b1, 1'b0, 22, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
        look();
        chk("t6_no_fd_entry", sb.stall, 0);
        drive(1'b1, 1'b0, 20, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
        #1;
        chk("t6_older_still_live", sb.stall, 1);
        sb.id_valid = 1'b0;
        #1;
        chk("t6_bubble_no_stall", sb.stall, 0);
        bubble();
        repeat (4) step();

        // f0 is an ordinary register
        drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        step();
        drive(1'b1, 1'b0, 3, 1'b0, 0, 1'b1, 5, 1'b1, 1'b0);
        look();
        chk("f0_raw_stall", sb.stall, 1);
        chk("f0_raw_fwd", sb.fwd_ft, 0);
        sb.id_use_ft = 1'b0;
        #1;
        chk("f0_unused_src", sb.stall, 0);
        bubble();
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
